// File: rtl/sar_search.sv
// Successive-approximation search: drives guess to an external comparator and resolves A MSB-first.
// Define SAR_SEARCH_EARLY_EXIT_EN to end the search as soon as the comparator reports equality.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StTry, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, idx_m1;
  logic [WIDTH-1:0]  guess_q, guess_d, result_q, result_d, work;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              legal;

  assign legal  = (cmp_gt + cmp_eq + cmp_lt) == 2'd1;
  assign idx_m1 = idx_q - IdxW'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    // Working value: the trial bit survives unless A is below the guess.
    work     = guess_q;
    if (cmp_lt) work[idx_q] = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          guess_d = {1'b1, {(WIDTH-1){1'b0}}};
          idx_d   = IdxW'(WIDTH-1);
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = StTry;
        end
      end
      StTry: begin
        if (!legal) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = StDone;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        end else if (cmp_eq) begin
          result_d = guess_q;
          done_d   = 1'b1;
          state_d  = StDone;
`endif
        end else begin
          guess_d = work;
          if (idx_q == '0) begin
            result_d = work;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            guess_d[idx_m1] = 1'b1;
            idx_d           = idx_m1;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= IdxW'(WIDTH-1);
      guess_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: stimulus pushes expected outcomes, a monitor checks each done pulse.
module tb_sar_search;
  localparam int W = 4;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
  localparam int LatEq8 = 1;
`else
  localparam int LatEq8 = 4;
`endif

  logic         clk = 1'b0;
  logic         rst, start, ill;
  logic [W-1:0] a_val;
  logic         cmp_gt, cmp_eq, cmp_lt;
  logic [W-1:0] guess, result;
  logic         busy, done, err;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  // Combinational comparator model; ill forces the illegal gt+lt code.
  assign cmp_gt = ill ? 1'b1 : (a_val > guess);
  assign cmp_eq = ill ? 1'b0 : (a_val == guess);
  assign cmp_lt = ill ? 1'b1 : (a_val < guess);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("err", 32'(err), 32'(e.err));
        check("latency", 32'(cyc - start_cyc), 32'(e.lat));
      end
    end
  end

  task automatic issue_start(input logic [W-1:0] a, input logic [W-1:0] res, input logic e_err,
                             input int lat);
    exp_t e;
    e.res = res;
    e.err = e_err;
    e.lat = lat;
    a_val = a;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    check("busy after start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      check("done timeout", 32'(done), 32'd1);
    end else begin
      check("busy in done cycle", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("busy after done", 32'(busy), 32'd0);
      check("done one cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] g9[4];
    g9[0] = 4'b1000; g9[1] = 4'b1100; g9[2] = 4'b1010; g9[3] = 4'b1001;
    rst = 1'b1; start = 1'b0; ill = 1'b0; a_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset guess", 32'(guess), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    // A=9 with the guess sequence
    issue_start(4'd9, 4'd9, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      check("guess a9", 32'(guess), 32'(g9[i]));
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    wait_done();

    issue_start(4'd8, 4'd8, 1'b0, LatEq8);
    wait_done();
    issue_start(4'd0, 4'd0, 1'b0, 4);
    wait_done();
    issue_start(4'd15, 4'd15, 1'b0, 4);
    wait_done();

    // Illegal code on the second TRY
    issue_start(4'd9, 4'd0, 1'b1, 2);
    @(posedge clk);
    #1;
    ill = 1'b1;
    @(posedge clk);
    #1;
    ill = 1'b0;
    wait_done();
    check("err held", 32'(err), 32'd1);
    check("result held", 32'(result), 32'd0);
    issue_start(4'd9, 4'd9, 1'b0, 4);
    check("err cleared", 32'(err), 32'd0);
    wait_done();

    // start held high throughout the search and the done cycle
    begin
      exp_t e;
      int n = 0;
      e.res = 4'd7; e.err = 1'b0; e.lat = 4;
      a_val = 4'd7;
      @(negedge clk);
      start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      while (!done && n < 40) begin
        check("busy held", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        n++;
      end
      check("done seen", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("no restart busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("no restart busy2", 32'(busy), 32'd0);
      check("no restart done", 32'(done), 32'd0);
    end

    // Reset during the third TRY
    a_val = 4'd9;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst guess", 32'(guess), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst err", 32'(err), 32'd0);
    rst = 1'b0;
    issue_start(4'd5, 4'd5, 1'b0, 4);
    check("guess a5", 32'(guess), 32'h8);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
